puf_challenge_sequencer: RTL and testbench

//  Drives the arbiter-PUF delay-line datapath: steps through NBITS challenges from a seed, fires

---
 rtl/puf_challenge_sequencer.sv | 146 ++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: steps NBITS challenges from a seed, fires VOTES launches per
// challenge, majority-votes the synchronised responses and reports a word plus instability mask.
module puf_challenge_sequencer #(
  parameter int unsigned CH_W   = 8,
  parameter int unsigned NBITS  = 8,
  parameter int unsigned VOTES  = 5,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CH_W-1:0]  seed,
  input  logic             puf_resp,
  output logic [CH_W-1:0]  puf_chal,
  output logic             puf_pulse,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] resp_word,
  output logic [NBITS-1:0] unstable
);

  localparam int unsigned VW   = $clog2(VOTES + 1);
  localparam int unsigned BW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned PMAX = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int unsigned CW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);
  localparam logic [CW-1:0] HoldLast   = CW'(HOLD - 1);
  localparam logic [VW-1:0] VotesV     = VW'(VOTES);
  localparam logic [VW-1:0] HalfV      = VW'(VOTES / 2);
  localparam logic [BW-1:0] LastBit    = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StHigh, StSample, StLow, StNext, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [VW-1:0]    vote_cnt_q;
  logic [VW-1:0]    ones_q;
  logic [BW-1:0]    bit_idx_q;
  logic [1:0]       sync_q;
  logic [CH_W-1:0]  chal_q;
  logic [NBITS-1:0] resp_q;
  logic [NBITS-1:0] unst_q;
  logic             last_bit;

  assign last_bit = (bit_idx_q == LastBit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSetup;
      StSetup:  if (cnt_q == SettleLast) state_d = StHigh;
      StHigh:   if (cnt_q == HoldLast) state_d = StSample;
      StSample: state_d = StLow;
      StLow: begin
        if (cnt_q == SettleLast) state_d = (vote_cnt_q < VotesV) ? StHigh : StNext;
      end
      StNext:   state_d = last_bit ? StDone : StSetup;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    puf_pulse = (state_q == StHigh) || (state_q == StSample);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
  end

  // Phase counter restarts on every state change so each timed phase counts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q == StSetup || state_q == StHigh || state_q == StLow) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], puf_resp};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chal_q     <= '0;
      bit_idx_q  <= '0;
      vote_cnt_q <= '0;
      ones_q     <= '0;
      resp_q     <= '0;
      unst_q     <= '0;
    end else if (!abort) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            chal_q     <= seed;
            bit_idx_q  <= '0;
            vote_cnt_q <= '0;
            ones_q     <= '0;
            resp_q     <= '0;
            unst_q     <= '0;
          end
        end
        StSample: begin
          ones_q     <= ones_q + VW'(sync_q[1]);
          vote_cnt_q <= vote_cnt_q + VW'(1);
        end
        StNext: begin
          resp_q[bit_idx_q] <= (ones_q > HalfV);
          unst_q[bit_idx_q] <= (ones_q != '0) && (ones_q != VotesV);
          vote_cnt_q        <= '0;
          ones_q            <= '0;
          if (!last_bit) begin
            bit_idx_q <= bit_idx_q + BW'(1);
            chal_q    <= chal_q + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign puf_chal  = chal_q;
  assign resp_word = resp_q;
  assign unstable  = unst_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer: parity PUF model with per-vote flip injection,
// table of full runs plus hand sequences for backpressure, abort and async reset.
module tb_puf_challenge_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic       puf_resp;
  logic [7:0] puf_chal;
  logic       puf_pulse;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] resp_word;
  logic [7:0] unstable;

  puf_challenge_sequencer #(
    .CH_W  (8),
    .NBITS (8),
    .VOTES (5),
    .SETTLE(4),
    .HOLD  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .seed     (seed),
    .puf_resp (puf_resp),
    .puf_chal (puf_chal),
    .puf_pulse(puf_pulse),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .resp_word(resp_word),
    .unstable (unstable)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // PUF model: parity of challenge, inverted on selected votes of one challenge.
  logic [7:0] flip_chal = 8'h00;
  logic [7:0] flip_mask = 8'h00;
  logic [2:0] vote_idx  = 3'd0;
  assign puf_resp = (^puf_chal) ^ ((puf_chal == flip_chal) && flip_mask[vote_idx]);

  logic       prev_pulse = 1'b0;
  logic [7:0] prev_chal  = 8'h00;
  int         launches   = 0;
  int         viol       = 0;
  int         log_n      = 0;
  logic [7:0] chal_log[2048];

  always @(posedge clk) begin
    prev_pulse <= puf_pulse;
    prev_chal  <= puf_chal;
    if (puf_pulse && !prev_pulse) launches <= launches + 1;
    if (prev_pulse && !puf_pulse && log_n < 2048) begin
      chal_log[log_n] <= puf_chal;
      log_n           <= log_n + 1;
    end
    if (puf_chal != prev_chal && (puf_pulse || prev_pulse)) viol <= viol + 1;
    if (!busy || puf_chal != prev_chal) vote_idx <= 3'd0;
    else if (prev_pulse && !puf_pulse) vote_idx <= vote_idx + 3'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] seed;
    logic [7:0] fchal;
    logic [7:0] fmask;
    logic [7:0] exp_resp;
    logic [7:0] exp_unst;
  } vec_t;

  vec_t vecs[7];

  task automatic run_check(input vec_t v, input int idx);
    int lat;
    int l0;
    int n0;
    int v0;
    int bad;
    string t;
    t         = $sformatf("v%0d", idx);
    flip_chal = v.fchal;
    flip_mask = v.fmask;
    seed      = v.seed;
    l0        = launches;
    n0        = log_n;
    v0        = viol;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({t, "_latency"}, lat, 401);
    chk({t, "_resp"}, resp_word, v.exp_resp);
    chk({t, "_unstable"}, unstable, v.exp_unst);
    @(posedge clk); #1;
    chk({t, "_idle_after"}, {busy, out_valid}, 2'b00);
    chk({t, "_launches"}, launches - l0, 40);
    chk({t, "_chal_change_in_pulse"}, viol - v0, 0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (chal_log[n0 + k] !== 8'(v.seed + k / 5)) bad++;
    end
    chk({t, "_chal_sequence"}, bad, 0);
    flip_mask = 8'h00;
  endtask

  initial begin
    int lat;
    int l0;
    int found;
    int held_bad;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h96, 8'h00};
    vecs[1] = '{8'hFE, 8'h00, 8'h00, 8'h59, 8'h00};
    vecs[2] = '{8'h01, 8'h04, 8'h05, 8'hCB, 8'h08};
    vecs[3] = '{8'h01, 8'h04, 8'h15, 8'hC3, 8'h08};
    vecs[4] = '{8'h00, 8'h05, 8'h1F, 8'hB6, 8'h00};
    vecs[5] = '{8'h00, 8'h00, 8'h01, 8'h96, 8'h01};
    vecs[6] = '{8'h00, 8'h07, 8'h0F, 8'h16, 8'h80};

    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    seed      = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_pulse", puf_pulse, 0);
    chk("reset_chal", puf_chal, 8'h00);
    chk("reset_resp", {resp_word, unstable}, 16'h0000);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort in IDLE together with start: abort wins, nothing starts.
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_idle_noop", busy, 0);

    for (int i = 0; i < 7; i++) run_check(vecs[i], i);

    // Backpressure in DONE, start pulses mid-run ignored, start with ready ignored.
    out_ready = 1'b0;
    seed      = 8'h01;
    l0        = launches;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 1000) begin
      start = (lat == 50 || lat == 200 || lat == 350);
      seed  = 8'hAA;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("bp_latency", lat, 401);
    held_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!out_valid || !busy || resp_word !== 8'hCB || unstable !== 8'h00) held_bad++;
    end
    chk("bp_held_stable", held_bad, 0);
    chk("bp_resp", resp_word, 8'hCB);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bp_release_idle", {busy, out_valid}, 2'b00);
    @(posedge clk); #1;
    chk("bp_start_with_ready_ignored", busy, 0);
    chk("bp_launches", launches - l0, 40);

    // Abort during HIGH of bit 4.
    seed  = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      @(posedge clk); #1;
      if (puf_chal == 8'h04 && puf_pulse) found = 1;
    end
    chk("abort_reach_bit4", found, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {busy, puf_pulse, out_valid}, 3'b000);
    chk("abort_resp_hold", {resp_word, unstable}, 16'h0600);
    held_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) held_bad++;
    end
    chk("abort_no_valid", held_bad, 0);
    run_check(vecs[0], 10);

    // Asynchronous reset mid-run, asserted off the clock edge.
    seed  = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    chk("rst_pre_state", {busy, puf_chal, resp_word}, {1'b1, 8'h02, 8'h02});
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {busy, puf_pulse, out_valid, puf_chal, resp_word, unstable},
        27'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_idle", {busy, out_valid}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
